// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: write-back select codes and the MEM-stage FSM encoding.
// Imported by the EX, EX/MEM and MEM/WB stages so all of them agree on the codes.
package mem_wb_stage_pkg;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_RAM = 2'd1;
  localparam logic [1:0] WSEL_WD  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // An instruction touches the data bus if it stores or loads its write-back value from RAM.
  function automatic logic is_access(input logic [1:0] wsel, input logic ram_we);
    return ram_we | (wsel == WSEL_RAM);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-bus connection between the MEM stage (master) and memory (slave).
interface mem_wb_stage_if;
  // Handshake: the master holds dbus_req and its address/data/we stable until a cycle
  // with dbus_ack high; that cycle completes the access and carries dbus_rdata.
  // dbus_ack is meaningless while dbus_req is low.
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_wb_stage_wb_sel_mux.sv
// Combinational write-back data selector for the MEM/WB stage.
module wb_sel_mux
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  wsel,
  input  logic [31:0] alu,
  input  logic [31:0] rdata,
  input  logic [31:0] wd,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = wd;
    case (wsel)
      WSEL_ALU: wdata = alu;
      WSEL_RAM: wdata = rdata;
      default:  wdata = wd;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: runs the data-bus access with a wait-cycle timeout and registers the
// write-back to the register file. Stalls upstream while a bus access is outstanding.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    men_rf_wsel,
  input  logic          men_rf_we,
  input  logic          men_ram_we,
  input  logic [31:0]   men_alu,
  input  logic [31:0]   men_wd,
  input  logic [4:0]    men_wR,
  input  logic [31:0]   men_rD2,
  mem_wb_stage_if.master dbus,
  output logic          mem_stall,
  output logic          wb_rf_we,
  output logic [4:0]    wb_wR,
  output logic [31:0]   wb_wD,
  output logic          bus_err,
  output mem_state_t    state_dbg
);

  localparam logic [7:0] CNT_MAX = 8'(BUS_TIMEOUT);

  mem_state_t  state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        access, req, ack, timeout;
  logic [31:0] sel_data;

  assign access = is_access(men_rf_wsel, men_ram_we);

  // Request is forced low during reset so an abandoned access never reaches the bus.
  assign req     = ~rst & (((state == ST_IDLE) & access) | (state == ST_WAIT));
  assign ack     = dbus.dbus_ack & req;
  // A late ack landing on the limit cycle still completes normally.
  assign timeout = (state == ST_WAIT) & (wait_cnt == CNT_MAX) & ~ack;

  assign dbus.dbus_req   = req;
  assign dbus.dbus_we    = req & men_ram_we;
  assign dbus.dbus_addr  = req ? men_alu : 32'd0;
  assign dbus.dbus_wdata = req ? men_rD2 : 32'd0;

  assign mem_stall = req & ~ack & ~timeout;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access & ~ack)   state_nxt = ST_WAIT;
      ST_WAIT: if (ack | timeout)   state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Counter sits at zero in IDLE, so it is already cleared on the first WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wait_cnt <= 8'd0;
    else if (state == ST_IDLE) wait_cnt <= 8'd0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end

  wb_sel_mux u_wb_sel_mux (
    .wsel  (men_rf_wsel),
    .alu   (men_alu),
    .rdata (dbus.dbus_rdata),
    .wd    (men_wd),
    .wdata (sel_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rf_we <= 1'b0;
      wb_wR    <= 5'd0;
      wb_wD    <= 32'd0;
    end else if (mem_stall) begin
      wb_rf_we <= 1'b0;
    end else begin
      wb_rf_we <= men_rf_we & ~timeout;
      wb_wR    <= men_wR;
      wb_wD    <= sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus_err <= 1'b0;
    else if (timeout) bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random instruction stream against a
// transaction-level model (instruction, how many request cycles it has seen, when ack comes).
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int T = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  men_rf_wsel = '0;
  logic        men_rf_we   = 1'b0;
  logic        men_ram_we  = 1'b0;
  logic [31:0] men_alu     = '0;
  logic [31:0] men_wd      = '0;
  logic [4:0]  men_wR      = '0;
  logic [31:0] men_rD2     = '0;
  logic        mem_stall, wb_rf_we, bus_err;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD;
  mem_state_t  state_dbg;

  mem_wb_stage_if dbus();

  mem_wb_stage #(.BUS_TIMEOUT(T)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .men_rf_wsel (men_rf_wsel),
    .men_rf_we   (men_rf_we),
    .men_ram_we  (men_ram_we),
    .men_alu     (men_alu),
    .men_wd      (men_wd),
    .men_wR      (men_wR),
    .men_rD2     (men_rD2),
    .dbus        (dbus),
    .mem_stall   (mem_stall),
    .wb_rf_we    (wb_rf_we),
    .wb_wR       (wb_wR),
    .wb_wD       (wb_wD),
    .bus_err     (bus_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int stall_seen = 0;

  logic        exp_req = 0, exp_we = 0, exp_stall = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  mem_state_t  exp_state = ST_IDLE;
  logic        exp_wb_we = 0, exp_err = 0;
  logic [4:0]  exp_wR = 0;
  logic [31:0] exp_wD = 0;
  logic [31:0] exp_q[$];  // loads' write-back data, in completion order

  logic [1:0]  cur_wsel;
  logic        cur_rf_we, cur_ram_we;
  logic [31:0] cur_alu, cur_wd, cur_rD2;
  logic [4:0]  cur_wR;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dbus_req",   {31'd0, dbus.dbus_req}, {31'd0, exp_req});
      chk("dbus_we",    {31'd0, dbus.dbus_we},  {31'd0, exp_we});
      chk("dbus_addr",  dbus.dbus_addr,         exp_addr);
      chk("dbus_wdata", dbus.dbus_wdata,        exp_wdata);
      chk("mem_stall",  {31'd0, mem_stall},     {31'd0, exp_stall});
      chk("state",      32'(state_dbg),         32'(exp_state));
      chk("wb_rf_we",   {31'd0, wb_rf_we},      {31'd0, exp_wb_we});
      chk("wb_wR",      {27'd0, wb_wR},         {27'd0, exp_wR});
      chk("wb_wD",      wb_wD,                  exp_wD);
      chk("bus_err",    {31'd0, bus_err},       {31'd0, exp_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [1:0] wsel, input logic rf_we, input logic ram_we,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rd2, input logic [4:0] wr);
    cur_wsel = wsel; cur_rf_we = rf_we; cur_ram_we = ram_we;
    cur_alu = alu; cur_wd = wd; cur_rD2 = rd2; cur_wR = wr;
    men_rf_wsel = wsel; men_rf_we = rf_we; men_ram_we = ram_we;
    men_alu = alu; men_wd = wd; men_rD2 = rd2; men_wR = wr;
  endtask

  // One clock of the current instruction; w = request cycles already spent on it.
  // Model: an access times out on its (T+2)-th request cycle unless acked there.
  task automatic drive_cycle(input int w, input int ack_at, input logic [31:0] rdata,
                             output bit done);
    bit acc, ack, to;
    acc = cur_ram_we | (cur_wsel == WSEL_RAM);
    ack = acc ? (w == ack_at) : 1'($urandom_range(0, 1));
    dbus.dbus_ack   = ack;
    dbus.dbus_rdata = (acc && ack) ? rdata : $urandom;
    to = acc && !ack && (w == T + 1);
    exp_req   = acc;
    exp_we    = acc & cur_ram_we;
    exp_addr  = acc ? cur_alu : 32'd0;
    exp_wdata = acc ? cur_rD2 : 32'd0;
    exp_stall = acc & !ack & !to;
    exp_state = (acc && w > 0) ? ST_WAIT : ST_IDLE;
    @(negedge clk);
    if (mem_stall) stall_seen++;
    @(posedge clk);
    done = !exp_stall;
    if (exp_stall) begin
      exp_wb_we = 1'b0;
    end else begin
      exp_wb_we = cur_rf_we & !to;
      exp_wR    = cur_wR;
      if (cur_wsel == WSEL_ALU)      exp_wD = cur_alu;
      else if (cur_wsel == WSEL_RAM) exp_wD = dbus.dbus_rdata;
      else                           exp_wD = cur_wd;
      if (cur_wsel == WSEL_RAM && !to) exp_q.push_back(dbus.dbus_rdata);
    end
    if (to) exp_err = 1'b1;
    #1;
  endtask

  task automatic run_instr(input int ack_at, input logic [31:0] rdata, output int cycles);
    bit done = 1'b0;
    int w = 0;
    while (!done && w < T + 4) begin
      drive_cycle(w, ack_at, rdata, done);
      w++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL run_instr: no completion after %0d cycles", w);
    end
    cycles = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit d;
    logic [31:0] q0, q1;
    dbus.dbus_ack = 1'b0;
    dbus.dbus_rdata = '0;

    #1;
    chk("rst_req",      {31'd0, dbus.dbus_req}, 32'd0);
    chk("rst_stall",    {31'd0, mem_stall},     32'd0);
    chk("rst_wb_rf_we", {31'd0, wb_rf_we},      32'd0);
    chk("rst_wb_wD",    wb_wD,                  32'd0);
    chk("rst_bus_err",  {31'd0, bus_err},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU op writes back one cycle later, no bus activity.
    set_instr(WSEL_ALU, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5);
    run_instr(0, 32'h0, n);
    chk("alu_cycles", n, 1);
    chk("alu_wD", wb_wD, 32'h0000_1234);
    chk("alu_wR", {27'd0, wb_wR}, 32'd5);
    chk("alu_we", {31'd0, wb_rf_we}, 32'd1);

    // Zero-wait load.
    stall_seen = 0;
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 5'd7);
    run_instr(0, 32'hCAFE_F00D, n);
    chk("zw_cycles", n, 1);
    chk("zw_stall", stall_seen, 0);
    chk("zw_wD", wb_wD, 32'hCAFE_F00D);

    // Store with three wait cycles.
    stall_seen = 0;
    set_instr(WSEL_ALU, 1'b0, 1'b1, 32'h8000_0020, 32'h0, 32'hA5A5_A5A5, 5'd0);
    run_instr(3, 32'h0, n);
    chk("st_cycles", n, 4);
    chk("st_stall", stall_seen, 3);
    chk("st_we", {31'd0, wb_rf_we}, 32'd0);

    // Reset in the middle of a load wait, then the same load completes.
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'h0, 5'd9);
    drive_cycle(0, -1, 32'h0, d);
    drive_cycle(1, -1, 32'h0, d);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_req",   {31'd0, dbus.dbus_req}, 32'd0);
    chk("mrst_stall", {31'd0, mem_stall},     32'd0);
    chk("mrst_state", 32'(state_dbg),         32'(ST_IDLE));
    chk("mrst_we",    {31'd0, wb_rf_we},      32'd0);
    chk("mrst_wR",    {27'd0, wb_wR},         32'd0);
    chk("mrst_wD",    wb_wD,                  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wb_we = 1'b0; exp_wR = '0; exp_wD = '0; exp_err = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    run_instr(1, 32'h1357_9BDF, n);
    chk("mrst_ld_cycles", n, 2);
    chk("mrst_ld_wD", wb_wD, 32'h1357_9BDF);
    chk("mrst_ld_wR", {27'd0, wb_wR}, 32'd9);

    // Ack arriving on the timeout cycle wins.
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 5'd4);
    run_instr(T + 1, 32'h0BAD_CAFE, n);
    chk("race_cycles", n, 6);
    chk("race_err", {31'd0, bus_err}, 32'd0);
    chk("race_we", {31'd0, wb_rf_we}, 32'd1);
    chk("race_wD", wb_wD, 32'h0BAD_CAFE);

    // Back-to-back loads, one wait each.
    stall_seen = 0;
    exp_q.delete();
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0300, 32'h0, 32'h0, 5'd10);
    run_instr(1, 32'h1111_0001, n);
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0304, 32'h0, 32'h0, 5'd11);
    run_instr(1, 32'h2222_0002, n);
    chk("b2b_stall", stall_seen, 2);
    chk("b2b_wD", wb_wD, 32'h2222_0002);
    q0 = exp_q.pop_front();
    q1 = exp_q.pop_front();
    chk("b2b_order0", q0, 32'h1111_0001);
    chk("b2b_order1", q1, 32'h2222_0002);

    // Load that never gets an ack.
    stall_seen = 0;
    set_instr(WSEL_RAM, 1'b1, 1'b0, 32'h8000_0400, 32'h0, 32'h0, 5'd3);
    run_instr(-1, 32'h0, n);
    chk("to_cycles", n, 6);
    chk("to_stall", stall_seen, 5);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_we", {31'd0, wb_rf_we}, 32'd0);
    set_instr(WSEL_WD, 1'b1, 1'b0, 32'h0000_0055, 32'hDEAD_BEEF, 32'h0, 5'd12);
    run_instr(0, 32'h0, n);
    chk("after_to_we", {31'd0, wb_rf_we}, 32'd1);
    chk("after_to_wD", wb_wD, 32'hDEAD_BEEF);

    // Random instruction stream.
    for (int i = 0; i < 200; i++) begin
      set_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)));
      run_instr($urandom_range(0, T + 2), $urandom, n);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 16, meaning the maximum cycles in WAIT before the access is aborted (range 1..255).
REQ-002 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports men_rf_wsel in 2 / men_rf_we in 1 / men_ram_we in 1, the write-back select, RF write enable and store enable from the EX/MEM register.
REQ-005 SHALL have ports men_alu in 32 / men_wd in 32 / men_wR in 5 / men_rD2 in 32, the ALU result (also the address), the alternate write data, the destination register and the store data.
REQ-006 SHALL have ports dbus_req out 1 / dbus_we out 1 / dbus_addr out 32 / dbus_wdata out 32, the data-bus request.
REQ-007 SHALL have ports dbus_ack in 1 / dbus_rdata in 32, the bus completion and the load data (valid with ack).
REQ-008 SHALL have port mem_stall out 1, which freezes all upstream pipeline registers while high.
REQ-009 SHALL have ports wb_rf_we out 1 / wb_wR out 5 / wb_wD out 32, the registered write-back to the register file.
REQ-010 SHALL have port bus_err out 1, a sticky flag indicating that a bus timeout occurred.

Function
REQ-011 SHALL define access = men_ram_we | (men_rf_wsel == WSEL_RAM); a load is an access with men_ram_we = 0.
REQ-012 SHALL implement a two-state FSM, IDLE and WAIT: IDLE->WAIT when access & ~dbus_ack; WAIT->IDLE on dbus_ack or on timeout; otherwise hold state.
REQ-013 SHALL drive dbus_req = (IDLE & access) | WAIT combinationally, so a zero-wait ack in IDLE completes in the same cycle.
REQ-014 SHALL drive dbus_addr = men_alu, dbus_wdata = men_rD2 and dbus_we = men_ram_we; all four are 0 when dbus_req = 0.
REQ-015 SHALL drive mem_stall = dbus_req & ~dbus_ack & ~timeout, combinationally.
REQ-016 SHALL raise timeout when the WAIT cycle counter equals BUS_TIMEOUT; the counter clears on entry to WAIT and counts once per WAIT cycle.
REQ-017 SHALL select write data: WSEL_ALU gives men_alu, WSEL_RAM gives dbus_rdata, and WSEL_WD or 2'b11 gives men_wd.
REQ-018 SHALL, on each rising edge with mem_stall = 0, load wb_wR <= men_wR, wb_wD <= the selected data and wb_rf_we <= men_rf_we & ~timeout.
REQ-019 SHALL, on each rising edge with mem_stall = 1, load wb_rf_we <= 0 (a bubble) and hold wb_wR and wb_wD.
REQ-020 SHALL latency: a non-access instruction appears on the wb_* outputs one cycle after it appears on the men_* inputs; an access appears one cycle after its ack.
REQ-021 SHALL set bus_err on timeout and clear it only by reset.
REQ-022 SHALL treat a timed-out load as no write-back (wb_rf_we = 0) and a timed-out store as dropped; the pipeline then proceeds.
REQ-023 SHALL ignore dbus_ack when dbus_req = 0.
REQ-024 SHALL, when ack and timeout occur in the same cycle, let ack win: normal completion, and bus_err is not set.

Reset
REQ-025 SHALL, on rst, asynchronously set state = IDLE, counter = 0, wb_rf_we = 0, wb_wR = 0, wb_wD = 0 and bus_err = 0.
REQ-026 SHALL abandon an access in flight when rst is asserted in WAIT; dbus_req falls during reset.
REQ-027 SHALL hold dbus_req, dbus_we and mem_stall at 0 while rst is high.

Structure
REQ-028 SHALL take WSEL_ALU = 2'd0, WSEL_RAM = 2'd1, WSEL_WD = 2'd2 and the FSM state encodings from the shared pipeline package also used by the EX and EX/MEM stages.
REQ-029 SHALL contain one sub-module, wb_sel_mux, the combinational write-data selector; the FSM, counter and WB register stay in mem_wb_stage.

Verification
REQ-030 SHALL cover ALU op: men_rf_wsel = 0, men_alu = 32'h0000_1234, men_wR = 5, men_rf_we = 1 -> next cycle wb_wD = 32'h1234, wb_wR = 5, wb_rf_we = 1, no dbus_req.
REQ-031 SHALL cover zero-wait load: wsel = 1, men_alu = 32'h8000_0010, dbus_ack = 1 with rdata = 32'hCAFE_F00D in the same cycle -> no stall, next cycle wb_wD = 32'hCAFE_F00D.
REQ-032 SHALL cover a 3-wait store: men_ram_we = 1, men_rD2 = 32'hA5A5_A5A5, ack on the 4th cycle -> mem_stall high for 3 cycles, dbus_we = 1, wdata stable, wb_rf_we = 0 throughout.
REQ-033 SHALL cover timeout with BUS_TIMEOUT = 4 and ack never asserted on a load -> stall released after 5 request cycles, bus_err = 1, wb_rf_we = 0, and the following ALU op writes back normally.
REQ-034 SHALL cover reset mid-WAIT: rst pulsed during cycle 2 of a load wait -> dbus_req = 0, state = IDLE, all wb_* outputs = 0, and a subsequent load completes correctly.
REQ-035 SHALL cover back-to-back loads with 1 wait each -> two bubbles, writes in order, the second load's address presented only after the first ack.
